// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser (FSM states, length-field width).
// The optional checksum stage is enabled by defining UART_CMD_CSUM_EN.
package uart_cmd_pkg;

  localparam int unsigned LEN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_LEN    = 3'd2,
    ST_ARGS   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_HOLD   = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Reloadable idle-cycle down-counter: expired is high once CYCLES enabled cycles
// have passed since the last clear. Reusable by other UART-facing blocks.
module uart_cmd_timeout #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned        CNT_W  = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0]   RELOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Reload on clear, count down while enabled, park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= RELOAD;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = en && (cnt_r == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command parser: SYNC, opcode, length, args -> one valid/ready command.
// Define UART_CMD_CSUM_EN to append an XOR checksum byte to every frame (enables err_csum).
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned        DATA_W         = 8,
  parameter int unsigned        MAX_ARGS       = 4,
  parameter logic [DATA_W-1:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned        TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         UART_Rx_Data_Ready,
  input  logic [DATA_W-1:0]            UART_Rx_Data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [DATA_W-1:0]            cmd_opcode,
  output logic [LEN_W-1:0]             cmd_len,
  output logic [MAX_ARGS*DATA_W-1:0]   cmd_args,
  output logic                         err_len,
  output logic                         err_timeout,
  output logic                         err_csum,
  output logic                         err_overrun
);

  localparam logic [DATA_W-1:0] MAX_ARGS_B = DATA_W'(MAX_ARGS);

`ifdef UART_CMD_CSUM_EN
  localparam cmd_state_e ST_FRAME_END = ST_CSUM;
`else
  localparam cmd_state_e ST_FRAME_END = ST_HOLD;
`endif

  cmd_state_e                 state_r;
  cmd_state_e                 state_s;

  logic                       byte_s;
  logic                       counting_s;
  logic                       accept_s;
  logic                       tmo_clear_s;
  logic                       tmo_expired_s;
  logic                       len_ok_s;
  logic                       len_zero_s;
  logic                       last_arg_s;

  logic                       start_frame_s;
  logic                       cap_opcode_s;
  logic                       cap_len_s;
  logic                       cap_arg_s;

  logic [DATA_W-1:0]          opcode_r;
  logic [LEN_W-1:0]           len_r;
  logic [LEN_W-1:0]           idx_r;
  logic [MAX_ARGS*DATA_W-1:0] args_r;

  logic                       cmd_valid_s;
  logic                       err_len_s;
  logic                       err_timeout_s;
  logic                       err_csum_s;
  logic                       err_overrun_s;
  logic                       cmd_valid_r;
  logic                       err_len_r;
  logic                       err_timeout_r;
  logic                       err_csum_r;
  logic                       err_overrun_r;

  assign byte_s      = UART_Rx_Data_Ready;
  assign counting_s  = (state_r == ST_OPCODE) || (state_r == ST_LEN) ||
                       (state_r == ST_ARGS)   || (state_r == ST_CSUM);
  // An expiring timeout swallows a byte that lands in the same cycle.
  assign accept_s    = byte_s && !tmo_expired_s;
  assign tmo_clear_s = byte_s || !counting_s;
  assign len_ok_s    = (UART_Rx_Data <= MAX_ARGS_B);
  assign len_zero_s  = (UART_Rx_Data == '0);
  assign last_arg_s  = (idx_r == (len_r - LEN_W'(1)));

  uart_cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear_s),
    .en      (counting_s),
    .expired (tmo_expired_s)
  );

`ifdef UART_CMD_CSUM_EN
  logic [DATA_W-1:0] csum_r;
  logic              csum_ok_s;

  function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] data);
    return acc ^ data;
  endfunction

  // XOR accumulator over opcode, length and argument bytes of the current frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= '0;
    end else if (start_frame_s) begin
      csum_r <= '0;
    end else if (cap_opcode_s || cap_len_s || cap_arg_s) begin
      csum_r <= csum_fold(csum_r, UART_Rx_Data);
    end else begin
      csum_r <= csum_r;
    end
  end

  assign csum_ok_s = (UART_Rx_Data == csum_r);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (byte_s && (UART_Rx_Data == SYNC_BYTE)) state_s = ST_OPCODE;
        else                                       state_s = ST_IDLE;
      end
      ST_OPCODE: begin
        if (tmo_expired_s) state_s = ST_IDLE;
        else if (byte_s)   state_s = ST_LEN;
        else               state_s = ST_OPCODE;
      end
      ST_LEN: begin
        if (tmo_expired_s)   state_s = ST_IDLE;
        else if (!byte_s)    state_s = ST_LEN;
        else if (!len_ok_s)  state_s = ST_IDLE;
        else if (len_zero_s) state_s = ST_FRAME_END;
        else                 state_s = ST_ARGS;
      end
      ST_ARGS: begin
        if (tmo_expired_s)            state_s = ST_IDLE;
        else if (byte_s && last_arg_s) state_s = ST_FRAME_END;
        else                          state_s = ST_ARGS;
      end
      ST_CSUM: begin
`ifdef UART_CMD_CSUM_EN
        if (tmo_expired_s)  state_s = ST_IDLE;
        else if (!byte_s)   state_s = ST_CSUM;
        else if (csum_ok_s) state_s = ST_HOLD;
        else                state_s = ST_IDLE;
`else
        state_s = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        if (cmd_valid_r && cmd_ready) state_s = ST_IDLE;
        else                          state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath-enable decode.
  always_comb begin
    start_frame_s = (state_r == ST_IDLE) && (state_s == ST_OPCODE);
    cap_opcode_s  = (state_r == ST_OPCODE) && accept_s;
    cap_len_s     = (state_r == ST_LEN) && accept_s && len_ok_s;
    cap_arg_s     = (state_r == ST_ARGS) && accept_s;
    cmd_valid_s   = (state_s == ST_HOLD);
    err_len_s     = (state_r == ST_LEN) && accept_s && !len_ok_s;
    err_timeout_s = tmo_expired_s;
    err_overrun_s = (state_r == ST_HOLD) && byte_s;
`ifdef UART_CMD_CSUM_EN
    err_csum_s    = (state_r == ST_CSUM) && accept_s && !csum_ok_s;
`else
    err_csum_s    = 1'b0;
`endif
  end

  // Frame fields; argument slots are wiped when a new frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r <= '0;
      len_r    <= '0;
      idx_r    <= '0;
      args_r   <= '0;
    end else begin
      if (cap_opcode_s) opcode_r <= UART_Rx_Data;
      if (cap_len_s) begin
        len_r <= UART_Rx_Data[LEN_W-1:0];
        idx_r <= '0;
      end else if (cap_arg_s) begin
        idx_r <= idx_r + LEN_W'(1);
      end
      if (start_frame_s) begin
        args_r <= '0;
      end else if (cap_arg_s) begin
        for (int i = 0; i < int'(MAX_ARGS); i++) begin
          if (idx_r == LEN_W'(i)) args_r[i*DATA_W +: DATA_W] <= UART_Rx_Data;
        end
      end
    end
  end

  // Registered command-valid and single-cycle error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_r   <= 1'b0;
      err_len_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      err_csum_r    <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      cmd_valid_r   <= cmd_valid_s;
      err_len_r     <= err_len_s;
      err_timeout_r <= err_timeout_s;
      err_csum_r    <= err_csum_s;
      err_overrun_r <= err_overrun_s;
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd_opcode  = opcode_r;
  assign cmd_len     = len_r;
  assign cmd_args    = args_r;
  assign err_len     = err_len_r;
  assign err_timeout = err_timeout_r;
  assign err_csum    = err_csum_r;
  assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser; follows UART_CMD_CSUM_EN if defined.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int         MAX_ARGS = 4;
  localparam int         TMO      = 40;
  localparam logic [7:0] SYNC     = 8'hAA;
`ifdef UART_CMD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int K_NONE = 0, K_CMD = 1, K_LEN = 2, K_CSUM = 3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        UART_Rx_Data_Ready;
  logic [7:0]  UART_Rx_Data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_args;
  logic        err_len, err_timeout, err_csum, err_overrun;

  int tests_run = 0, tests_failed = 0;
  int n_len = 0, n_tmo = 0, n_csum = 0, n_ovr = 0, n_cmd = 0;
  int e_len = 0, e_tmo = 0, e_csum = 0, e_ovr = 0, e_cmd = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .DATA_W(8), .MAX_ARGS(MAX_ARGS), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .UART_Rx_Data_Ready(UART_Rx_Data_Ready), .UART_Rx_Data(UART_Rx_Data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_args(cmd_args),
    .err_len(err_len), .err_timeout(err_timeout),
    .err_csum(err_csum), .err_overrun(err_overrun)
  );

  // Event monitor: counts pulse-cycles and completed handshakes.
  always @(posedge clk) begin
    if (err_len === 1'b1)     n_len++;
    if (err_timeout === 1'b1) n_tmo++;
    if (err_csum === 1'b1)    n_csum++;
    if (err_overrun === 1'b1) n_ovr++;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) n_cmd++;
  end

  task automatic send_byte(input logic [7:0] b);
    UART_Rx_Data_Ready = 1'b1;
    UART_Rx_Data       = b;
    @(posedge clk); #1;
    UART_Rx_Data_Ready = 1'b0;
    UART_Rx_Data       = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference: parse a byte stream from IDLE using the frame rules.
  function automatic void model(input bq_t q, output int kind, output logic [7:0] op,
                                output logic [3:0] len, output logic [31:0] args);
    int i, n;
    logic [7:0] x;
    kind = K_NONE; op = 8'h00; len = 4'h0; args = 32'h0;
    i = 0;
    while (i < q.size() && q[i] != SYNC) i++;
    if (i + 2 >= q.size()) return;
    op = q[i+1];
    n  = int'(q[i+2]);
    if (n > MAX_ARGS) begin kind = K_LEN; return; end
    len = 4'(n);
    x   = op ^ q[i+2];
    for (int k = 0; k < n; k++) begin
      args[8*k +: 8] = q[i+3+k];
      x = x ^ q[i+3+k];
    end
    if (CSUM_EN && q[i+3+n] != x) kind = K_CSUM;
    else                          kind = K_CMD;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cmd_ready = 1'b0; UART_Rx_Data_Ready = 1'b0; UART_Rx_Data = 8'h00;
    #12;
    tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", cmd_valid); end
    tests_run++; if ({err_len, err_timeout, err_csum, err_overrun} !== 4'b0000) begin tests_failed++; $display("FAIL reset_err: got %b exp 0000", {err_len, err_timeout, err_csum, err_overrun}); end
    tests_run++; if ({cmd_opcode, cmd_len, cmd_args} !== 44'h0) begin tests_failed++; $display("FAIL reset_fields: got %h exp 0", {cmd_opcode, cmd_len, cmd_args}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_vectors();
`ifdef UART_CMD_CSUM_EN
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tests_run++; if (err_csum !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL csum_bad: got csum=%b valid=%b exp 1/0", err_csum, cmd_valid); end
    e_csum++;
    idle(1);
    tests_run++; if (err_csum !== 1'b0) begin tests_failed++; $display("FAIL csum_pulse_width: got %b exp 0", err_csum); end
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
`else
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
`endif
    tests_run++; if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h10 || cmd_len !== 4'd2 || cmd_args !== 32'h0000_2211) begin tests_failed++; $display("FAIL vec_cmd2: got v=%b op=%h len=%0d args=%h exp 1/10/2/00002211", cmd_valid, cmd_opcode, cmd_len, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
    tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL vec_handshake: got %b exp 0", cmd_valid); end
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00);
`ifdef UART_CMD_CSUM_EN
    send_byte(8'h05);
`endif
    tests_run++; if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h05 || cmd_len !== 4'd0 || cmd_args !== 32'h0) begin tests_failed++; $display("FAIL vec_len0: got v=%b op=%h len=%0d args=%h exp 1/05/0/0", cmd_valid, cmd_opcode, cmd_len, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
`ifdef UART_CMD_CSUM_EN
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00); send_byte(8'h07);
    tests_run++; if (err_csum !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL vec_len0_badcsum: got csum=%b valid=%b exp 1/0", err_csum, cmd_valid); end
    e_csum++;
`endif
    idle(2);
  endtask

  task automatic test_len_error();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05);
    tests_run++; if (err_len !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL len_err: got err=%b valid=%b exp 1/0", err_len, cmd_valid); end
    e_len++;
    idle(1);
    tests_run++; if (err_len !== 1'b0) begin tests_failed++; $display("FAIL len_err_width: got %b exp 0", err_len); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef UART_CMD_CSUM_EN
    send_byte(8'h41);
`endif
    tests_run++; if (cmd_valid !== 1'b1 || cmd_len !== 4'd4 || cmd_args !== 32'h4433_2211 || err_len !== 1'b0) begin tests_failed++; $display("FAIL len_max: got v=%b len=%0d args=%h exp 1/4/44332211", cmd_valid, cmd_len, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
    idle(1);
  endtask

  task automatic test_timeout();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
    idle(TMO - 1);
    tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_early: got %b exp 0", err_timeout); end
    idle(1);
    tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL tmo_pulse: got %b exp 1", err_timeout); end
    e_tmo++;
    idle(1);
    tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_width: got %b exp 0", err_timeout); end
    // A byte on the expiry cycle must be dropped.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h11);
    idle(TMO - 1);
    send_byte(8'h22);
    tests_run++; if (err_timeout !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL tmo_wins: got tmo=%b valid=%b exp 1/0", err_timeout, cmd_valid); end
    e_tmo++;
    idle(1);
    send_byte(8'hAA); send_byte(8'h42); send_byte(8'h01); send_byte(8'h99);
`ifdef UART_CMD_CSUM_EN
    send_byte(8'hDA);
`endif
    tests_run++; if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h42 || cmd_args !== 32'h99) begin tests_failed++; $display("FAIL tmo_resync: got v=%b op=%h args=%h exp 1/42/00000099", cmd_valid, cmd_opcode, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
    idle(1);
  endtask

  task automatic test_overrun();
    send_byte(8'hAA); send_byte(8'h20); send_byte(8'h01); send_byte(8'h5A);
`ifdef UART_CMD_CSUM_EN
    send_byte(8'h7B);
`endif
    idle(3);
    send_byte(SYNC);
    tests_run++; if (err_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_pulse: got %b exp 1", err_overrun); end
    e_ovr++;
    idle(1);
    tests_run++; if (err_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_width: got %b exp 0", err_overrun); end
    idle(5);
    tests_run++; if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h20 || cmd_len !== 4'd1 || cmd_args !== 32'h5A) begin tests_failed++; $display("FAIL ovr_stable: got v=%b op=%h len=%0d args=%h exp 1/20/1/0000005a", cmd_valid, cmd_opcode, cmd_len, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
    idle(2);
    tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_single_cmd: got %b exp 0", cmd_valid); end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({cmd_valid, cmd_opcode, cmd_len, cmd_args} !== 45'h0) begin tests_failed++; $display("FAIL rst_mid_outputs: got %h exp 0", {cmd_valid, cmd_opcode, cmd_len, cmd_args}); end
    @(posedge clk); #1;
    tests_run++; if ({err_len, err_timeout, err_csum, err_overrun} !== 4'b0000) begin tests_failed++; $display("FAIL rst_mid_err: got %b exp 0000", {err_len, err_timeout, err_csum, err_overrun}); end
    rst = 1'b0;
    idle(1);
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h01); send_byte(8'h44);
`ifdef UART_CMD_CSUM_EN
    send_byte(8'h76);
`endif
    tests_run++; if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h33 || cmd_args !== 32'h44) begin tests_failed++; $display("FAIL rst_mid_next: got v=%b op=%h args=%h exp 1/33/00000044", cmd_valid, cmd_opcode, cmd_args); end
    cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
    idle(1);
  endtask

  task automatic test_random_frames();
    bq_t        q;
    int         kind, n, h;
    logic [7:0] op, b, x;
    logic [3:0] len;
    logic [31:0] args;
    for (int f = 0; f < 40; f++) begin
      q = {};
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        q.push_back(b);
      end
      op = 8'($urandom);
      q.push_back(SYNC); q.push_back(op);
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(MAX_ARGS + 1, 255));
      else                           n = int'($urandom_range(0, MAX_ARGS));
      q.push_back(8'(n));
      x = op ^ 8'(n);
      if (n <= MAX_ARGS) begin
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          q.push_back(b);
          x = x ^ b;
        end
        if (CSUM_EN) begin
          if ($urandom_range(0, 5) == 0) x = x ^ 8'($urandom_range(1, 255));
          q.push_back(x);
        end
      end
      model(q, kind, op, len, args);
      foreach (q[i]) begin
        idle(int'($urandom_range(0, 2)));
        send_byte(q[i]);
      end
      case (kind)
        K_CMD: begin
          tests_run++; if (cmd_valid !== 1'b1 || {cmd_opcode, cmd_len, cmd_args} !== {op, len, args}) begin tests_failed++; $display("FAIL rnd_cmd[%0d]: got v=%b %h/%0d/%h exp 1 %h/%0d/%h", f, cmd_valid, cmd_opcode, cmd_len, cmd_args, op, len, args); end
          h = int'($urandom_range(0, 3));
          for (int c = 0; c < h; c++) begin
            idle(1);
            tests_run++; if (cmd_valid !== 1'b1 || {cmd_opcode, cmd_len, cmd_args} !== {op, len, args}) begin tests_failed++; $display("FAIL rnd_hold[%0d]: got v=%b %h/%0d/%h exp 1 %h/%0d/%h", f, cmd_valid, cmd_opcode, cmd_len, cmd_args, op, len, args); end
          end
          cmd_ready = 1'b1; idle(1); cmd_ready = 1'b0; e_cmd++;
          tests_run++; if (cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_release[%0d]: got %b exp 0", f, cmd_valid); end
        end
        K_LEN: begin
          tests_run++; if (err_len !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_len[%0d]: got err=%b valid=%b exp 1/0", f, err_len, cmd_valid); end
          e_len++;
          idle(1);
        end
        K_CSUM: begin
          tests_run++; if (err_csum !== 1'b1 || cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_csum[%0d]: got err=%b valid=%b exp 1/0", f, err_csum, cmd_valid); end
          e_csum++;
          idle(1);
        end
        default: idle(1);
      endcase
    end
    idle(2);
  endtask

  task automatic test_event_totals();
    tests_run++; if (n_cmd !== e_cmd) begin tests_failed++; $display("FAIL total_cmd: got %0d exp %0d", n_cmd, e_cmd); end
    tests_run++; if (n_len !== e_len) begin tests_failed++; $display("FAIL total_err_len: got %0d exp %0d", n_len, e_len); end
    tests_run++; if (n_tmo !== e_tmo) begin tests_failed++; $display("FAIL total_err_timeout: got %0d exp %0d", n_tmo, e_tmo); end
    tests_run++; if (n_csum !== e_csum) begin tests_failed++; $display("FAIL total_err_csum: got %0d exp %0d", n_csum, e_csum); end
    tests_run++; if (n_ovr !== e_ovr) begin tests_failed++; $display("FAIL total_err_overrun: got %0d exp %0d", n_ovr, e_ovr); end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_len_error();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random_frames();
    test_event_totals();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
